// File: rtl/acq_sequencer_pkg.sv
// acq_sequencer_pkg: state codes and default widths shared by the acquisition sequencer.
package acq_sequencer_pkg;

    localparam int unsigned ACQ_AW = 12;
    localparam int unsigned ACQ_DW = 16;
    localparam int unsigned ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_PRE  = 3'd2,
        ST_ARM  = 3'd3,
        ST_POST = 3'd4,
        ST_DONE = 3'd5,
        ST_AUTO = 3'd6
    } acq_state_e;

endpackage

// File: rtl/acq_tick_div.sv
// acq_tick_div: sample-rate divider, one registered tick every tdiv+1 enabled cycles.
module acq_tick_div
    import acq_sequencer_pkg::*;
#(
    parameter int unsigned DW = ACQ_DW
) (
    input  logic          Mclk,
    input  logic          nReset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] tdiv,
    output logic          tick
);

    logic [DW-1:0] cnt;

    // en reflects the state of the coming cycle, so tick only lands in active states
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr || !en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == tdiv) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + DW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: clears/arms the trigger block, fills pre-trigger window, counts post-trigger samples.
// Build option: define ACQ_SEQUENCER_AUTO_TRIG_EN to enable the ARM auto-trigger timeout.
module acq_sequencer
    import acq_sequencer_pkg::*;
#(
    parameter int unsigned AW = ACQ_AW,
    parameter int unsigned DW = ACQ_DW
) (
    input  logic          Mclk,
    input  logic          nReset,
    input  logic          Go,
    input  logic          Abort,
    input  logic [DW-1:0] Tdiv,
    input  logic [AW-1:0] PreTrig,
    input  logic [15:0]   TrigTimeout,
    input  logic          Start,
    output logic          TrigRst,
    output logic          Sampled,
    output logic          WrEn,
    output logic [AW-1:0] WrAddr,
    output logic [AW-1:0] TrigAddr,
    output logic          Ready,
    output logic [2:0]    State
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(1) << AW;

    acq_state_e    state, state_nxt;
    logic [AW-1:0] pre_trig_q;
    logic [CW-1:0] cnt;
    logic          trig_c, force_c, tick_en_c;
    logic          trig_rst_nxt, sampled_nxt, ready_nxt;

    assign State = state;

    acq_tick_div #(.DW(DW)) u_tick_div (
        .Mclk   (Mclk),
        .nReset (nReset),
        .clr    (Go),
        .en     (tick_en_c),
        .tdiv   (Tdiv),
        .tick   (WrEn)
    );

`ifdef ACQ_SEQUENCER_AUTO_TRIG_EN
    logic [15:0] to_cnt;

    // ARM ticks since ARM entry; the tick that reaches TrigTimeout forces the trigger
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            to_cnt <= '0;
        end else if (state != ST_ARM) begin
            to_cnt <= '0;
        end else if (WrEn) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    assign force_c = (state == ST_ARM) && (TrigTimeout != 16'd0) && WrEn && !Start
                     && ((to_cnt + 16'd1) == TrigTimeout);
`else
    logic unused_trig_timeout;
    assign unused_trig_timeout = ^TrigTimeout;
    assign force_c = 1'b0;
`endif

    // next state and next registered outputs
    always_comb begin
        state_nxt = state;
        trig_c    = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_CLR:  state_nxt = (pre_trig_q == '0) ? ST_ARM : ST_PRE;
            ST_PRE:  if (WrEn && cnt == CW'(1)) state_nxt = ST_ARM;
            ST_ARM: begin
                if (Start || force_c) begin
                    trig_c    = 1'b1;
                    state_nxt = Start ? ST_POST : ST_AUTO;
                end
            end
            ST_AUTO, ST_POST: state_nxt = (WrEn && cnt == CW'(1)) ? ST_DONE : ST_POST;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (Go)    state_nxt = ST_CLR;
        if (Abort) state_nxt = ST_IDLE;

        tick_en_c    = state_nxt inside {ST_PRE, ST_ARM, ST_AUTO, ST_POST};
        trig_rst_nxt = state_nxt inside {ST_IDLE, ST_CLR, ST_DONE};
        sampled_nxt  = state_nxt inside {ST_ARM, ST_AUTO, ST_POST};
        ready_nxt    = (state_nxt == ST_DONE);
    end

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_IDLE;
            TrigRst <= 1'b1;
            Sampled <= 1'b0;
            Ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            TrigRst <= trig_rst_nxt;
            Sampled <= sampled_nxt;
            Ready   <= ready_nxt;
        end
    end

    // write address, trigger address and the shared pre/post sample counter
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            pre_trig_q <= '0;
            cnt        <= '0;
            WrAddr     <= '0;
            TrigAddr   <= '0;
        end else if (Abort) begin
            WrAddr <= WrAddr + AW'(WrEn);
        end else if (Go) begin
            pre_trig_q <= PreTrig;
            WrAddr     <= '0;
        end else begin
            WrAddr <= WrAddr + AW'(WrEn);
            case (state)
                ST_CLR: cnt <= CW'(pre_trig_q);
                ST_PRE, ST_AUTO, ST_POST: if (WrEn) cnt <= cnt - CW'(1);
                ST_ARM: begin
                    if (trig_c) begin
                        TrigAddr <= WrAddr + AW'(WrEn);
                        cnt      <= FULL_CNT - CW'(pre_trig_q);
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Sequences one acquisition around the trigger/edge-measurement block: clears it, fills the pre-trigger window, arms it via Sampled, waits for Start, then counts post-trigger samples.
- Generates the sample-buffer write strobe/address and latches the trigger address for the MCU.
- Sits between the MCU register file and the trigger block, on Mclk.

Parameters:
AW, 12, buffer address width; buffer holds 2^AW samples, addresses wrap modulo 2^AW
DW, 16, sample-rate divider width

Ports:
Mclk  input  1  main clock
nReset  input  1  asynchronous active-low reset
Go  input  1  one-cycle pulse: start new acquisition (restarts if busy)
Abort  input  1  one-cycle pulse: return to IDLE
Tdiv  input  DW  sample tick every Tdiv+1 Mclk cycles
PreTrig  input  AW  pre-trigger sample count, sampled at Go
TrigTimeout  input  16  auto-trigger timeout in sample ticks (AUTO_TRIG_EN only)
Start  input  1  trigger status from trigger block, active high
TrigRst  output  1  reset to trigger block, active high
Sampled  output  1  arm qualifier to trigger block
WrEn  output  1  buffer write strobe, one Mclk per sample tick
WrAddr  output  AW  buffer write address
TrigAddr  output  AW  WrAddr at trigger acceptance
Ready  output  1  acquisition complete, held until Go/Abort
State  output  3  current state code, for status register

Behaviour:
- Reset (nReset low, async): state IDLE; TrigRst=1, Sampled=0, WrEn=0, WrAddr=0, TrigAddr=0, Ready=0, State=0, divider and counters 0.
- Sample tick: DW-bit divider counts 0..Tdiv in PRE/ARM/POST, tick on terminal count; Tdiv=0 gives tick every cycle. Divider clears on Go.
- WrEn = tick in PRE/ARM/POST; WrAddr increments after each write, wraps 2^AW-1 -> 0.
- States (code): IDLE=0, CLR=1, PRE=2, ARM=3, POST=4, DONE=5.
- IDLE: TrigRst=1. Go -> CLR; latch PreTrig, WrAddr<=0, Ready<=0.
- CLR: exactly one cycle, TrigRst=1 -> PRE (or ARM directly when latched PreTrig=0).
- PRE: TrigRst=0, Sampled=0; count ticks; after PreTrig writes -> ARM. Start ignored.
- ARM: Sampled=1; buffer written circularly. Start=1 sampled on Mclk -> POST next cycle, TrigAddr<=WrAddr (address of next write), post counter loaded with 2^AW-PreTrig.
- POST: Sampled=1; decrement per tick; at last write -> DONE. Start ignored.
- DONE: Ready=1, Sampled=0, TrigRst=1, WrEn=0; hold until Go (-> CLR) or Abort (-> IDLE).
- Go in any state -> CLR (restart, same as from IDLE). Abort in any state -> IDLE, Ready=0. Go and Abort same cycle: Abort wins.
- Start and tick same cycle in ARM: the write completes at current WrAddr; TrigAddr = WrAddr+1.
- Post counter width AW+1; PreTrig=0 gives full 2^AW post samples.
- All outputs registered; no combinational path input->output.

Optional Feature:
- Macro: ACQ_SEQUENCER_AUTO_TRIG_EN.
- With it: 16-bit timeout counter cleared on ARM entry, increments per tick in ARM; on reaching TrigTimeout (non-zero) forces trigger as if Start=1 in that cycle. TrigTimeout=0 disables. State code 6 (AUTO) is reported for the single cycle of a forced trigger, then POST.
- Without it: TrigTimeout unused; ARM waits indefinitely for Start.

Decomposition:
- Shared package: state encoding constants (IDLE..DONE, AUTO=6), default AW/DW.
- One sub-module, acq_tick_div: DW-bit divider with clear and tick output.
- Sequencer FSM, address and counters stay in the top.

Test Plan:
- Reset mid-POST (nReset low 3 cycles): all outputs return to reset values immediately; State=0, TrigRst=1.
- AW=4, Tdiv=0, PreTrig=5, Go; Start pulsed 10 cycles after ARM entry -> 5 writes in PRE, 16-5=11 writes in POST, Ready=1, TrigAddr=(5+10) mod 16=15, WrAddr wraps 15->0.
- Tdiv=3, PreTrig=2 -> WrEn every 4th Mclk; ARM entered after 8 Mclk of PRE.
- PreTrig=0, Go -> CLR directly to ARM; Start -> exactly 16 post writes (AW=4).
- Go during ARM -> one CLR cycle with TrigRst=1, WrAddr=0; Go+Abort same cycle -> IDLE.
- AUTO_TRIG_EN, TrigTimeout=7, no Start -> forced trigger after 7 ARM ticks, State=6 one cycle, then POST; TrigTimeout=0 -> no forced trigger.
